// File: rtl/joy_serial_pkg.sv
// Shared types and constants for the serial joystick reader.
// Bit helpers map a serial sample index k onto (player, button bit).
package joy_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LEAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam int DEF_NUM_PLAYERS     = 2;
  localparam int DEF_BITS_PER_PLAYER = 12;
  localparam int DEF_HALF_PERIOD     = 128;
  localparam int DEF_LEAD_SLOTS      = 2;
  localparam int DEF_DEBOUNCE        = 2;

  function automatic int bit_player(input int k, input int b);
    return k / b;
  endfunction

  // First sample of each player is its most significant button bit.
  function automatic int bit_pos(input int k, input int b);
    return b - 1 - (k % b);
  endfunction

  function automatic int bit_flat(input int k, input int b);
    return bit_player(k, b) * b + bit_pos(k, b);
  endfunction

endpackage

// File: rtl/joy_serial_np_debounce.sv
// One button bit of the frame filter: previous raw value, saturating
// agreement counter and the published output bit, with a clear input.
module joy_debounce_bit
  import joy_serial_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_update,
  input  logic i_clear,
  input  logic i_raw,
  output logic o_out
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic          r_prev;
  logic          r_out;

  always_comb begin
    w_cnt_n = r_cnt;
    if (i_raw != r_prev) begin
      w_cnt_n = {CW{1'b0}};
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_n = r_cnt;
    end else begin
      w_cnt_n = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= {CW{1'b0}};
      r_prev <= 1'b0;
      r_out  <= 1'b0;
    end else if (i_update) begin
      if (i_clear) begin
        r_cnt  <= {CW{1'b0}};
        r_prev <= 1'b0;
        r_out  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_n;
        r_prev <= i_raw;
        if (w_cnt_n == CNT_MAX) begin
          r_out <= i_raw;
        end
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/joy_serial_np.sv
// Serial joystick splitter reader: generates JOY_CLK/JOY_LOAD from clk,
// shifts in N*B active-low bits per frame, debounces and flags disconnects.
module joy_serial_np
  import joy_serial_pkg::*;
#(
  parameter int NUM_PLAYERS     = DEF_NUM_PLAYERS,
  parameter int BITS_PER_PLAYER = DEF_BITS_PER_PLAYER,
  parameter int HALF_PERIOD     = DEF_HALF_PERIOD,
  parameter int LEAD_SLOTS      = DEF_LEAD_SLOTS,
  parameter int DEBOUNCE        = DEF_DEBOUNCE
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   enable,
  input  logic                                   JOY_DATA,
  output logic                                   JOY_CLK,
  output logic                                   JOY_LOAD,
  output logic [NUM_PLAYERS*BITS_PER_PLAYER-1:0] joystick,
  output logic [NUM_PLAYERS-1:0]                 connected,
  output logic                                   frame_valid
);

  localparam int NB     = NUM_PLAYERS * BITS_PER_PLAYER;
  localparam int DIV_W  = $clog2(2 * HALF_PERIOD);
  localparam int SLOT_W = $clog2(LEAD_SLOTS + NB + 1);
  localparam logic [DIV_W-1:0]  DIV_HALF       = DIV_W'(HALF_PERIOD);
  localparam logic [DIV_W-1:0]  DIV_LAST       = DIV_W'(2 * HALF_PERIOD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LEAD_LAST = SLOT_W'(LEAD_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(LEAD_SLOTS + NB - 1);

  state_t                 r_state;
  state_t                 w_state_n;
  logic [DIV_W-1:0]       r_div;
  logic [DIV_W-1:0]       w_div_n;
  logic [SLOT_W-1:0]      r_slot;
  logic [SLOT_W-1:0]      w_slot_n;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   w_tick;
  logic                   w_commit;
  logic [NB-1:0]          r_raw;
  logic [NB-1:0]          w_raw_full;
  logic [NB-1:0]          w_sample;
  logic [NUM_PLAYERS-1:0] w_absent;
  logic [NUM_PLAYERS-1:0] r_connected;
  logic                   r_joy_clk;
  logic                   r_joy_load;
  logic                   r_frame_valid;

  assign w_tick = (r_div == DIV_HALF);

  // Slot sequencing; dropping enable aborts the frame from any state.
  always_comb begin
    w_state_n = r_state;
    w_slot_n  = r_slot;
    w_commit  = 1'b0;
    if (!enable) begin
      w_state_n = ST_IDLE;
      w_slot_n  = {SLOT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_LOAD;
          w_slot_n  = {SLOT_W{1'b0}};
        end
        ST_LOAD: begin
          if (w_tick) begin
            w_slot_n  = SLOT_W'(1);
            w_state_n = (LEAD_SLOTS == 1) ? ST_SHIFT : ST_LEAD;
          end else begin
            w_state_n = ST_LOAD;
          end
        end
        ST_LEAD: begin
          if (w_tick) begin
            w_slot_n  = r_slot + SLOT_W'(1);
            w_state_n = (r_slot == SLOT_LEAD_LAST) ? ST_SHIFT : ST_LEAD;
          end else begin
            w_state_n = ST_LEAD;
          end
        end
        ST_SHIFT: begin
          if (w_tick && (r_slot == SLOT_LAST)) begin
            w_commit  = 1'b1;
            w_slot_n  = {SLOT_W{1'b0}};
            w_state_n = ST_COMMIT;
          end else if (w_tick) begin
            w_slot_n  = r_slot + SLOT_W'(1);
          end else begin
            w_state_n = ST_SHIFT;
          end
        end
        ST_COMMIT: begin
          w_slot_n  = {SLOT_W{1'b0}};
          w_state_n = ST_LOAD;
        end
        default: begin
          w_slot_n  = {SLOT_W{1'b0}};
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Divider is parked at zero while idle and restarts with the first LOAD slot.
  always_comb begin
    w_div_n = r_div;
    if ((r_state == ST_IDLE) || (w_state_n == ST_IDLE)) begin
      w_div_n = {DIV_W{1'b0}};
    end else if (r_div == DIV_LAST) begin
      w_div_n = {DIV_W{1'b0}};
    end else begin
      w_div_n = r_div + DIV_W'(1);
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_sample
    localparam int J = bit_flat(k, BITS_PER_PLAYER);
    assign w_sample[k]   = (r_state == ST_SHIFT) && w_tick && (r_slot == SLOT_W'(LEAD_SLOTS + k));
    assign w_raw_full[J] = w_sample[k] ? ~r_sync2 : r_raw[J];
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    assign w_absent[p] = &w_raw_full[p*BITS_PER_PLAYER +: BITS_PER_PLAYER];
    for (genvar b = 0; b < BITS_PER_PLAYER; b++) begin : g_bit
      joy_debounce_bit #(
        .DEBOUNCE (DEBOUNCE)
      ) u_deb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_update (w_commit),
        .i_clear  (w_absent[p]),
        .i_raw    (w_raw_full[p*BITS_PER_PLAYER + b]),
        .o_out    (joystick[p*BITS_PER_PLAYER + b])
      );
    end
  end

  // Sequencer, synchroniser and registered pin/strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_div         <= {DIV_W{1'b0}};
      r_slot        <= {SLOT_W{1'b0}};
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_raw         <= {NB{1'b0}};
      r_connected   <= {NUM_PLAYERS{1'b0}};
      r_joy_clk     <= 1'b0;
      r_joy_load    <= 1'b1;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_div         <= w_div_n;
      r_slot        <= w_slot_n;
      r_sync1       <= JOY_DATA;
      r_sync2       <= r_sync1;
      r_raw         <= w_raw_full;
      r_joy_clk     <= (w_div_n >= DIV_HALF);
      r_joy_load    <= (w_state_n != ST_LOAD);
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_connected <= ~w_absent;
      end
    end
  end

  assign JOY_CLK     = r_joy_clk;
  assign JOY_LOAD    = r_joy_load;
  assign connected   = r_connected;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_joy_serial_np.sv
// Scoreboard bench: splitter shift-register models feed two reader
// configurations; expected frames are queued with stimulus, checked on frame_valid.
module tb_joy_serial_np;

  typedef struct packed {
    logic [23:0] joy;
    logic [1:0]  conn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        enable_a, enable_b;
  logic        data_a, data_b;
  logic        jclk_a, jclk_b, load_a, load_b, fv_a, fv_b;
  logic [23:0] joy_a;
  logic [7:0]  joy_b;
  logic [1:0]  conn_a;
  logic [0:0]  conn_b;

  logic [23:0] word_a = 24'hFFFFFF;
  logic [7:0]  word_b = 8'hFF;
  logic [24:0] sr_a = 25'h1FFFFFF;
  logic [7:0]  sr_b = 8'hFF;
  logic        jclk_a_d = 1'b0, jclk_b_d = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad = 0;

  joy_serial_np #(
    .NUM_PLAYERS(2), .BITS_PER_PLAYER(12), .HALF_PERIOD(128), .LEAD_SLOTS(2), .DEBOUNCE(2)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable_a), .JOY_DATA(data_a),
    .JOY_CLK(jclk_a), .JOY_LOAD(load_a), .joystick(joy_a), .connected(conn_a),
    .frame_valid(fv_a)
  );

  joy_serial_np #(
    .NUM_PLAYERS(1), .BITS_PER_PLAYER(8), .HALF_PERIOD(4), .LEAD_SLOTS(1), .DEBOUNCE(1)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable_b), .JOY_DATA(data_b),
    .JOY_CLK(jclk_b), .JOY_LOAD(load_b), .joystick(joy_b), .connected(conn_b),
    .frame_valid(fv_b)
  );

  // Splitter models: parallel load while LOAD is low, shift on each JOY_CLK rise.
  always @(negedge clk) begin
    if (!load_a) sr_a <= {1'b1, word_a};
    else if (jclk_a && !jclk_a_d) sr_a <= {sr_a[23:0], 1'b1};
    jclk_a_d <= jclk_a;
    if (!load_b) sr_b <= word_b;
    else if (jclk_b && !jclk_b_d) sr_b <= {sr_b[6:0], 1'b1};
    jclk_b_d <= jclk_b;
  end

  assign data_a = sr_a[24];
  assign data_b = sr_b[7];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fv(input bit sel, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(sel ? fv_b : fv_a) && cyc < 8000);
    check_val("fv_seen", {31'd0, (sel ? fv_b : fv_a)}, 32'd1);
  endtask

  task automatic pop_check(input bit sel);
    exp_t e;
    e = '1;
    if (sel) begin
      if (q_b.size() > 0) e = q_b.pop_front();
      check_val("joy_b", {24'd0, joy_b}, {8'd0, e.joy});
      check_val("conn_b", {31'd0, conn_b}, {30'd0, e.conn});
    end else begin
      if (q_a.size() > 0) e = q_a.pop_front();
      check_val("joy_a", {8'd0, joy_a}, {8'd0, e.joy});
      check_val("conn_a", {30'd0, conn_a}, {30'd0, e.conn});
    end
  endtask

  task automatic frame_a(input logic [11:0] p0, input logic [11:0] p1,
                         input logic [23:0] ejoy, input logic [1:0] econn);
    int cyc;
    word_a = {p0, p1};
    q_a.push_back({ejoy, econn});
    wait_fv(1'b0, cyc);
    pop_check(1'b0);
  endtask

  initial begin
    int   cyc;
    int   rises;
    int   nfv;
    logic prev;

    reset_n  = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    word_b   = 8'h5A;
    repeat (3) @(negedge clk);
    check_val("rst_jclk", {31'd0, jclk_a}, 32'd0);
    check_val("rst_load", {31'd0, load_a}, 32'd1);
    check_val("rst_joy", {8'd0, joy_a}, 32'd0);
    check_val("rst_conn", {30'd0, conn_a}, 32'd0);
    check_val("rst_fv", {31'd0, fv_a}, 32'd0);

    reset_n = 1'b1;
    @(negedge clk);
    enable_a = 1'b1;
    @(negedge clk);
    check_val("load_low", {31'd0, load_a}, 32'd0);

    frame_a(12'hFFE, 12'hFFF, 24'h000000, 2'b11);
    @(negedge clk);
    check_val("fv_one_cycle", {31'd0, fv_a}, 32'd0);
    frame_a(12'hFFE, 12'hFFF, 24'h000001, 2'b11);
    frame_a(12'hFFE, 12'hFF7, 24'h000001, 2'b11);
    frame_a(12'hFFE, 12'hFFF, 24'h000001, 2'b11);
    frame_a(12'hFFE, 12'h000, 24'h000001, 2'b01);
    frame_a(12'hFFE, 12'hFFF, 24'h000001, 2'b11);

    // abort at slot 10: frame discarded, outputs held
    word_a = {12'h7FE, 12'h7FF};
    rises = 0;
    cyc   = 0;
    prev  = jclk_a;
    while (rises < 10 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (jclk_a && !prev) rises++;
      prev = jclk_a;
    end
    enable_a = 1'b0;
    @(negedge clk);
    check_val("abort_jclk", {31'd0, jclk_a}, 32'd0);
    check_val("abort_load", {31'd0, load_a}, 32'd1);
    check_val("abort_joy", {8'd0, joy_a}, 32'h000001);
    check_val("abort_conn", {30'd0, conn_a}, 32'd3);
    nfv = 0;
    repeat (4500) begin
      @(negedge clk);
      if (fv_a) nfv++;
    end
    check_val("abort_no_fv", nfv, 32'd0);

    q_a.push_back({24'h000001, 2'b11});
    enable_a = 1'b1;
    rises = 0;
    cyc   = 0;
    prev  = jclk_a;
    while (!fv_a && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (jclk_a && !prev) rises++;
      prev = jclk_a;
    end
    check_val("fv_seen", {31'd0, fv_a}, 32'd1);
    check_val("frame_slots", rises, 32'd26);
    pop_check(1'b0);
    frame_a(12'h7FE, 12'h7FF, 24'h800801, 2'b11);

    // asynchronous reset in the middle of SHIFT
    word_a = {12'hFFE, 12'hFFF};
    repeat (3000) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_jclk", {31'd0, jclk_a}, 32'd0);
    check_val("mid_rst_load", {31'd0, load_a}, 32'd1);
    check_val("mid_rst_joy", {8'd0, joy_a}, 32'd0);
    check_val("mid_rst_conn", {30'd0, conn_a}, 32'd0);
    check_val("mid_rst_fv", {31'd0, fv_a}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("restart_load", {31'd0, load_a}, 32'd0);
    frame_a(12'hFFE, 12'hFFF, 24'h000000, 2'b11);
    frame_a(12'hFFE, 12'hFFF, 24'h000001, 2'b11);

    // small configuration, no filtering
    q_b.push_back({24'h0000A5, 2'b01});
    enable_b = 1'b1;
    wait_fv(1'b1, cyc);
    pop_check(1'b1);
    word_b = 8'h0F;
    q_b.push_back({24'h0000F0, 2'b01});
    wait_fv(1'b1, cyc);
    check_val("period_b", cyc, 32'd72);
    pop_check(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joy_serial_np.md
# joy_serial_np

Parametrised serial joystick reader for shift-register controller splitters: N players × B buttons per frame, generated entirely in the `clk` domain (no derived clock), with input synchronisation, per-bit frame debounce, per-player disconnect detection and a frame-valid strobe. Sits between the DB15 splitter pins and the core's input mapping. Outputs are active-high button vectors; remapping to core button layout happens downstream.

## Interface
- `NUM_PLAYERS`, 2, players per frame (1..4).
- `BITS_PER_PLAYER`, 12, serial bits per player (4..16).
- `HALF_PERIOD`, 128, `clk` cycles per half period of `JOY_CLK` (≥4).
- `LEAD_SLOTS`, 2, serial slots from LOAD-low slot to first data slot (≥1).
- `DEBOUNCE`, 2, consecutive identical frames needed to change an output bit (1 = no filtering; 1..7).

- `clk` in 1: system clock, 48–50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: high = scan continuously; low = idle.
- `JOY_DATA` in 1: serial data from splitter, active-low buttons.
- `JOY_CLK` out 1: serial shift clock.
- `JOY_LOAD` out 1: parallel-load strobe, active-low.
- `joystick` out NUM_PLAYERS*BITS_PER_PLAYER: debounced buttons, active-high; player p occupies `[p*B +: B]`.
- `connected` out NUM_PLAYERS: per-player presence flag.
- `frame_valid` out 1: one-cycle pulse when `joystick`/`connected` update.

## Operation
- `JOY_DATA` passes through a 2-flop synchroniser before use.
- Divider `div` counts 0..2*HALF_PERIOD-1, wraps. `JOY_CLK` = registered (div ≥ HALF_PERIOD). A "tick" is the cycle div == HALF_PERIOD (rising edge of `JOY_CLK`).
- Slot counter advances once per tick; frame length = LEAD_SLOTS + N*B slots.
- States: IDLE, LOAD, LEAD, SHIFT, COMMIT.
  - IDLE: div held 0, `JOY_CLK` low, `JOY_LOAD` high. enable=1 → LOAD.
  - LOAD: slot 0; `JOY_LOAD` low for the whole slot; next tick → LEAD (or SHIFT if LEAD_SLOTS=1).
  - LEAD: slots 1..LEAD_SLOTS-1, `JOY_LOAD` high, no sampling.
  - SHIFT: at each tick, sample synchronised data into raw bit k (k = slot − LEAD_SLOTS); k maps to player k / B, bit B−1−(k mod B). After sample k = N*B−1 → COMMIT.
  - COMMIT: single `clk` cycle; filter update; `frame_valid`=1; → LOAD (next tick starts new slot 0). Divider keeps running.
- Raw value inverted: pressed = 1.
- Debounce per bit: counter saturating at DEBOUNCE−1; counter reset when raw ≠ previous raw, else increments; output bit takes raw value when counter reaches DEBOUNCE−1 at COMMIT. DEBOUNCE=1 → output = raw at every COMMIT.
- Disconnect: player whose inverted raw frame is all-ones (data line stuck low) → `connected[p]`=0, its output bits forced 0, its debounce counters and previous-raw cleared, at that COMMIT. First non-all-ones frame → `connected[p]`=1; outputs then follow normal debounce.
- enable falls mid-frame: abort at next `clk` edge to IDLE; partial raw frame discarded; `joystick`, `connected` hold; no `frame_valid`.
- All arithmetic unsigned; slot counter width clog2(LEAD_SLOTS+N*B+1).

## Timing
- Reset values: `JOY_CLK`=0, `JOY_LOAD`=1, `joystick`=0, `connected`=0, `frame_valid`=0, state IDLE, all counters 0.
- enable rise → `JOY_LOAD` low on next `clk` edge.
- Frame period = (LEAD_SLOTS+N*B)*2*HALF_PERIOD `clk` cycles; defaults 26*256 = 6656.
- `frame_valid` asserts the cycle after the last-sample tick; outputs valid in that same cycle.
- Press-to-output latency: DEBOUNCE frames plus ≤1 frame.
- Reset mid-frame: all state cleared asynchronously; scanning restarts from LOAD after release if enable=1.

## Structure
- Package `joy_serial_pkg`: state enum, default parameter constants, bit-index helper function (k → player, bit).
- One sub-module natural: `joy_debounce_bit` (counter + previous-raw + output flop, with clear input), instantiated N*B times.

## Test plan
- Defaults, splitter model driving player 0 raw 0xFFE, player 1 0xFFF for 2 frames → `joystick`=0x000_001 after second `frame_valid`, `connected`=2'b11.
- Single-frame glitch on bit 3 of player 1, DEBOUNCE=2 → `joystick` unchanged, no output pulse.
- Player 1 data all zero → at that COMMIT `connected`=2'b01, `joystick[23:12]`=0; next normal frame → `connected`=2'b11.
- enable dropped at slot 10 → `JOY_CLK` low, `JOY_LOAD` high next cycle, outputs held, no `frame_valid`; re-enable → full 26-slot frame.
- reset_n pulsed mid-SHIFT → all outputs at reset values immediately, restart from LOAD.
- N=1, B=8, HALF_PERIOD=4, LEAD_SLOTS=1, DEBOUNCE=1 → frame = 72 cycles, raw 0x5A → `joystick`=0xA5 at first `frame_valid`.
